// File: rtl/npuarc_alb_dmp_ibp_wr_seq_pkg.sv
// Shared definitions for the DMP IBP sequencers: FSM state encoding and
// the outstanding-response counter width.
package npuarc_dmp_ibp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } seq_state_e;

    // Enough bits to hold 0..max_out inclusive.
    function automatic int out_cnt_w(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/npuarc_alb_dmp_ibp_wr_seq_if.sv
// IBP write port: command channel, write-beat channel and write response.
interface npuarc_alb_dmp_ibp_wr_seq_if #(
    parameter int ADDR_W = 40,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 4
);
    logic                  ibp_cmd_valid;
    logic                  ibp_cmd_accept;
    logic                  ibp_cmd_read;
    logic [ADDR_W-1:0]     ibp_cmd_addr;
    logic [LEN_W-1:0]      ibp_cmd_burst_size;
    logic                  ibp_wr_valid;
    logic                  ibp_wr_accept;
    logic [DATA_W-1:0]     ibp_wr_data;
    logic [DATA_W/8-1:0]   ibp_wr_mask;
    logic                  ibp_wr_last;
    logic                  ibp_wr_done;
    logic                  ibp_err_wr;
    logic                  ibp_wr_resp_accept;

    modport master (
        output ibp_cmd_valid, ibp_cmd_read, ibp_cmd_addr, ibp_cmd_burst_size,
               ibp_wr_valid, ibp_wr_data, ibp_wr_mask, ibp_wr_last,
               ibp_wr_resp_accept,
        input  ibp_cmd_accept, ibp_wr_accept, ibp_wr_done, ibp_err_wr
    );

    modport slave (
        input  ibp_cmd_valid, ibp_cmd_read, ibp_cmd_addr, ibp_cmd_burst_size,
               ibp_wr_valid, ibp_wr_data, ibp_wr_mask, ibp_wr_last,
               ibp_wr_resp_accept,
        output ibp_cmd_accept, ibp_wr_accept, ibp_wr_done, ibp_err_wr
    );
endinterface

// File: rtl/npuarc_alb_dmp_ibp_out_cnt.sv
// Saturating up/down count of issued-but-unanswered transactions; flags a
// response that arrives when nothing is outstanding.
module npuarc_alb_dmp_ibp_out_cnt
    import npuarc_dmp_ibp_pkg::*;
#(
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = out_cnt_w(MAX_OUT)
) (
    input  logic             clk,
    input  logic             rst_a,
    input  logic             inc,
    input  logic             resp,
    output logic [CNT_W-1:0] cnt,
    output logic             unexp_resp
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    logic [CNT_W-1:0] cnt_nxt;
    logic             stray;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_nxt = cnt;
        stray   = 1'b0;
        if (inc && !resp) begin
            if (cnt != MAX_CNT) cnt_nxt = cnt + CNT_W'(1);
        end else if (resp && !inc) begin
            if (cnt == '0) stray   = 1'b1;
            else           cnt_nxt = cnt - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            cnt        <= '0;
            unexp_resp <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            unexp_resp <= stray;
        end
    end

endmodule

// File: rtl/npuarc_alb_dmp_ibp_wr_seq.sv
// Turns one buffered write request plus its data stream into an IBP write
// command followed by len+1 beats, throttled by outstanding responses.
module npuarc_alb_dmp_ibp_wr_seq
    import npuarc_dmp_ibp_pkg::*;
#(
    parameter int ADDR_W  = 40,
    parameter int DATA_W  = 64,
    parameter int LEN_W   = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  rst_a,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [LEN_W-1:0]      req_len,
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [DATA_W-1:0]     wd_data,
    input  logic [DATA_W/8-1:0]   wd_mask,
    npuarc_alb_dmp_ibp_wr_seq_if.master ibp,
    output logic                  wr_err,
    output logic                  unexp_resp,
    output logic                  busy
);
    localparam int               CNT_W   = out_cnt_w(MAX_OUT);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    seq_state_e        state_q, state_nxt;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [LEN_W-1:0]  cmd_len_q;
    logic [LEN_W-1:0]  beat_cnt_q;
    logic [CNT_W-1:0]  out_cnt;
    logic              wr_err_q;

    logic req_ready_c, cmd_valid_c, wr_valid_c, wd_ready_c, wr_last_c;
    logic req_hs, cmd_hs, beat_hs;

    always_comb begin
        state_nxt   = state_q;
        req_ready_c = 1'b0;
        cmd_valid_c = 1'b0;
        wr_valid_c  = 1'b0;
        wd_ready_c  = 1'b0;
        wr_last_c   = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by reset so ready stays low while rst_a is held.
                req_ready_c = !rst_a && (out_cnt < MAX_CNT);
                if (req_valid && req_ready_c) state_nxt = CMD;
            end
            CMD: begin
                cmd_valid_c = 1'b1;
                if (ibp.ibp_cmd_accept) state_nxt = DATA;
            end
            DATA: begin
                wr_valid_c = wd_valid;
                wd_ready_c = ibp.ibp_wr_accept;
                wr_last_c  = (beat_cnt_q == '0);
                if (wd_valid && ibp.ibp_wr_accept && wr_last_c) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign req_hs  = req_valid && req_ready_c;
    assign cmd_hs  = cmd_valid_c && ibp.ibp_cmd_accept;
    assign beat_hs = wr_valid_c && wd_ready_c;

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) state_q <= IDLE;
        else       state_q <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            cmd_addr_q <= '0;
            cmd_len_q  <= '0;
            beat_cnt_q <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            if (req_hs) begin
                cmd_addr_q <= req_addr;
                cmd_len_q  <= req_len;
            end
            if (cmd_hs)       beat_cnt_q <= cmd_len_q;
            else if (beat_hs) beat_cnt_q <= beat_cnt_q - LEN_W'(1);
            wr_err_q <= ibp.ibp_err_wr;
        end
    end

    // Done and error together are a single response.
    npuarc_alb_dmp_ibp_out_cnt #(
        .MAX_OUT (MAX_OUT),
        .CNT_W   (CNT_W)
    ) u_out_cnt (
        .clk        (clk),
        .rst_a      (rst_a),
        .inc        (cmd_hs),
        .resp       (ibp.ibp_wr_done || ibp.ibp_err_wr),
        .cnt        (out_cnt),
        .unexp_resp (unexp_resp)
    );

    assign req_ready              = req_ready_c;
    assign wd_ready               = wd_ready_c;
    assign ibp.ibp_cmd_valid      = cmd_valid_c;
    assign ibp.ibp_cmd_read       = 1'b0;
    assign ibp.ibp_cmd_addr       = cmd_addr_q;
    assign ibp.ibp_cmd_burst_size = cmd_len_q;
    assign ibp.ibp_wr_valid       = wr_valid_c;
    assign ibp.ibp_wr_data        = wd_data;
    assign ibp.ibp_wr_mask        = wd_mask;
    assign ibp.ibp_wr_last        = wr_last_c;
    assign ibp.ibp_wr_resp_accept = 1'b1;
    assign wr_err                 = wr_err_q;
    assign busy                   = (state_q != IDLE) || (out_cnt != '0);

endmodule

// File: tb/tb_npuarc_alb_dmp_ibp_wr_seq.sv
// Directed bench for the IBP write sequencer, built with MAX_OUT = 2 so the
// throttle limit is reached with two single-beat writes.
module tb_npuarc_alb_dmp_ibp_wr_seq;
    logic        clk = 1'b0;
    logic        rst_a = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [39:0] req_addr = '0;
    logic [3:0]  req_len = '0;
    logic        wd_valid = 1'b0;
    logic        wd_ready;
    logic [63:0] wd_data = '0;
    logic [7:0]  wd_mask = '0;
    logic        wr_err, unexp_resp, busy;

    int total = 0;
    int bad   = 0;

    npuarc_alb_dmp_ibp_wr_seq_if #(.ADDR_W(40), .DATA_W(64), .LEN_W(4)) ibp_bus ();

    npuarc_alb_dmp_ibp_wr_seq #(
        .ADDR_W(40), .DATA_W(64), .LEN_W(4), .MAX_OUT(2)
    ) dut (
        .clk        (clk),
        .rst_a      (rst_a),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .wd_valid   (wd_valid),
        .wd_ready   (wd_ready),
        .wd_data    (wd_data),
        .wd_mask    (wd_mask),
        .ibp        (ibp_bus),
        .wr_err     (wr_err),
        .unexp_resp (unexp_resp),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // One len-0 write with all accepts high; ends back in IDLE.
    task automatic single_burst(input logic [39:0] addr);
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = 4'd0;
        settle();
        tick();
        req_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic pulse_done();
        ibp_bus.ibp_wr_done = 1'b1;
        settle();
        tick();
        ibp_bus.ibp_wr_done = 1'b0;
        settle();
    endtask

    initial begin
        int b;
        int k;
        logic acc;

        ibp_bus.ibp_cmd_accept = 1'b0;
        ibp_bus.ibp_wr_accept  = 1'b0;
        ibp_bus.ibp_wr_done    = 1'b1;
        ibp_bus.ibp_err_wr     = 1'b0;
        req_valid = 1'b1;

        // Reset state, with a request and a response pending at the inputs
        tick();
        tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_valid", ibp_bus.ibp_cmd_valid, 0);
        check("rst_wr_valid", ibp_bus.ibp_wr_valid, 0);
        check("rst_wd_ready", wd_ready, 0);
        check("rst_unexp", unexp_resp, 0);
        check("rst_wr_err", wr_err, 0);
        check("rst_cmd_addr", ibp_bus.ibp_cmd_addr, 0);
        check("cmd_read", ibp_bus.ibp_cmd_read, 0);
        check("resp_accept", ibp_bus.ibp_wr_resp_accept, 1);
        req_valid = 1'b0;
        ibp_bus.ibp_wr_done = 1'b0;
        rst_a = 1'b0;
        tick();

        // Single beat at 0x1000
        ibp_bus.ibp_cmd_accept = 1'b1;
        ibp_bus.ibp_wr_accept  = 1'b1;
        req_valid = 1'b1;
        req_addr  = 40'h1000;
        req_len   = 4'd0;
        wd_valid  = 1'b1;
        wd_data   = 64'hDEAD_BEEF_0123_4567;
        wd_mask   = 8'hF0;
        settle();
        check("t1_req_ready", req_ready, 1);
        check("t1_idle_cmd_valid", ibp_bus.ibp_cmd_valid, 0);
        tick();
        req_valid = 1'b0;
        settle();
        check("t1_cmd_valid", ibp_bus.ibp_cmd_valid, 1);
        check("t1_cmd_addr", ibp_bus.ibp_cmd_addr, 40'h1000);
        check("t1_cmd_size", ibp_bus.ibp_cmd_burst_size, 0);
        check("t1_cmd_no_beat", ibp_bus.ibp_wr_valid, 0);
        check("t1_cmd_busy", busy, 1);
        tick();
        check("t1_wr_valid", ibp_bus.ibp_wr_valid, 1);
        check("t1_wr_last", ibp_bus.ibp_wr_last, 1);
        check("t1_wr_data", ibp_bus.ibp_wr_data, 64'hDEAD_BEEF_0123_4567);
        check("t1_wr_mask", ibp_bus.ibp_wr_mask, 8'hF0);
        check("t1_wd_ready", wd_ready, 1);
        check("t1_data_cmd_valid", ibp_bus.ibp_cmd_valid, 0);
        tick();
        check("t1_idle_wr_valid", ibp_bus.ibp_wr_valid, 0);
        check("t1_busy_wait_resp", busy, 1);
        check("t1_ready_out1", req_ready, 1);
        pulse_done();
        check("t1_busy_after_done", busy, 0);
        check("t1_no_unexp", unexp_resp, 0);

        // Four-beat burst with ibp_wr_accept toggling 1010...
        req_valid = 1'b1;
        req_addr  = 40'h2000;
        req_len   = 4'd3;
        settle();
        tick();
        req_valid = 1'b0;
        settle();
        check("t2_cmd_size", ibp_bus.ibp_cmd_burst_size, 3);
        tick();
        b = 0;
        k = 0;
        while (b < 4 && k < 20) begin
            acc = (k % 2 == 0);
            ibp_bus.ibp_wr_accept = acc;
            wd_data = 64'hA0 + 64'(b);
            settle();
            check("t2_wd_ready", wd_ready, acc);
            check("t2_wr_valid", ibp_bus.ibp_wr_valid, 1);
            check("t2_wr_last", ibp_bus.ibp_wr_last, (b == 3));
            check("t2_wr_data", ibp_bus.ibp_wr_data, 64'hA0 + 64'(b));
            tick();
            if (acc) b++;
            k++;
        end
        ibp_bus.ibp_wr_accept = 1'b1;
        settle();
        check("t2_done_wr_valid", ibp_bus.ibp_wr_valid, 0);
        check("t2_done_wd_ready", wd_ready, 0);
        check("t2_done_req_ready", req_ready, 1);
        pulse_done();
        check("t2_busy_clear", busy, 0);

        // Command stall: accept held low for 5 cycles, request inputs change
        ibp_bus.ibp_cmd_accept = 1'b0;
        req_valid = 1'b1;
        req_addr  = 40'h3000;
        req_len   = 4'd1;
        settle();
        tick();
        req_valid = 1'b0;
        req_addr  = 40'hFF_FFFF_FFFF;
        req_len   = 4'hF;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("t3_cmd_valid", ibp_bus.ibp_cmd_valid, 1);
            check("t3_cmd_addr", ibp_bus.ibp_cmd_addr, 40'h3000);
            check("t3_cmd_size", ibp_bus.ibp_cmd_burst_size, 1);
            check("t3_no_beat", ibp_bus.ibp_wr_valid, 0);
            check("t3_no_wd_ready", wd_ready, 0);
            tick();
        end
        ibp_bus.ibp_cmd_accept = 1'b1;
        settle();
        check("t3_cmd_valid_acc", ibp_bus.ibp_cmd_valid, 1);
        tick();
        check("t3_beat0_valid", ibp_bus.ibp_wr_valid, 1);
        check("t3_beat0_last", ibp_bus.ibp_wr_last, 0);
        tick();
        check("t3_beat1_last", ibp_bus.ibp_wr_last, 1);
        tick();
        pulse_done();
        check("t3_busy_clear", busy, 0);

        // Throttle at MAX_OUT = 2 with no responses
        req_valid = 1'b1;
        req_addr  = 40'h4000;
        req_len   = 4'd0;
        settle();
        check("t4_a_ready", req_ready, 1);
        tick();
        tick();
        tick();
        check("t4_b_ready", req_ready, 1);
        tick();
        tick();
        tick();
        check("t4_c_blocked", req_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_c_held", req_ready, 0);
            check("t4_c_no_cmd", ibp_bus.ibp_cmd_valid, 0);
            check("t4_busy", busy, 1);
        end
        ibp_bus.ibp_wr_done = 1'b1;
        settle();
        check("t4_ready_during_done", req_ready, 0);
        tick();
        ibp_bus.ibp_wr_done = 1'b0;
        settle();
        check("t4_c_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        settle();
        check("t4_c_cmd_valid", ibp_bus.ibp_cmd_valid, 1);
        tick();
        tick();
        check("t4_full_again", req_ready, 0);

        // Command accept coinciding with a response at out_cnt = 1
        pulse_done();
        req_valid = 1'b1;
        req_addr  = 40'h5000;
        req_len   = 4'd0;
        settle();
        check("t5_ready_out1", req_ready, 1);
        tick();
        req_valid = 1'b0;
        ibp_bus.ibp_wr_done = 1'b1;
        settle();
        check("t5_cmd_valid", ibp_bus.ibp_cmd_valid, 1);
        tick();
        ibp_bus.ibp_wr_done = 1'b0;
        settle();
        tick();
        check("t5_ready_still_out1", req_ready, 1);
        check("t5_busy_out1", busy, 1);
        pulse_done();
        check("t5_busy_clear", busy, 0);

        // Error response, stray response, combined done+error
        single_burst(40'h6000);
        ibp_bus.ibp_err_wr = 1'b1;
        settle();
        tick();
        ibp_bus.ibp_err_wr = 1'b0;
        settle();
        check("t6_wr_err_pulse", wr_err, 1);
        check("t6_err_no_unexp", unexp_resp, 0);
        check("t6_err_busy", busy, 0);
        tick();
        check("t6_wr_err_end", wr_err, 0);
        pulse_done();
        check("t6_unexp_pulse", unexp_resp, 1);
        check("t6_unexp_busy", busy, 0);
        check("t6_unexp_no_err", wr_err, 0);
        tick();
        check("t6_unexp_end", unexp_resp, 0);
        check("t6_out_held0", busy, 0);
        single_burst(40'h6100);
        single_burst(40'h6200);
        ibp_bus.ibp_wr_done = 1'b1;
        ibp_bus.ibp_err_wr  = 1'b1;
        settle();
        tick();
        ibp_bus.ibp_wr_done = 1'b0;
        ibp_bus.ibp_err_wr  = 1'b0;
        settle();
        check("t6_both_wr_err", wr_err, 1);
        check("t6_both_one_resp", req_ready, 1);
        check("t6_both_busy", busy, 1);
        pulse_done();
        check("t6_both_clear", busy, 0);

        // Reset asserted mid-DATA
        ibp_bus.ibp_wr_accept = 1'b0;
        req_valid = 1'b1;
        req_addr  = 40'h7000;
        req_len   = 4'd3;
        settle();
        tick();
        tick();
        check("t7_in_data", ibp_bus.ibp_wr_valid, 1);
        check("t7_addr", ibp_bus.ibp_cmd_addr, 40'h7000);
        ibp_bus.ibp_wr_accept = 1'b1;
        rst_a = 1'b1;
        settle();
        check("t7_rst_wr_valid", ibp_bus.ibp_wr_valid, 0);
        check("t7_rst_wd_ready", wd_ready, 0);
        check("t7_rst_cmd_valid", ibp_bus.ibp_cmd_valid, 0);
        check("t7_rst_cmd_addr", ibp_bus.ibp_cmd_addr, 0);
        check("t7_rst_cmd_size", ibp_bus.ibp_cmd_burst_size, 0);
        check("t7_rst_wr_last", ibp_bus.ibp_wr_last, 0);
        check("t7_rst_req_ready", req_ready, 0);
        check("t7_rst_busy", busy, 0);
        tick();
        rst_a = 1'b0;
        req_valid = 1'b0;
        settle();
        check("t7_post_ready", req_ready, 1);
        check("t7_post_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
